// File: rtl/reward_rx.sv
// Receive side of the reward exchange: reads a reward packet from packet RAM, checks it
// against this node, then updates the Q-table entry for the action and its neighbour ID.
module reward_rx #(
  parameter logic [10:0] RX_BASE     = 11'h248,
  parameter logic [10:0] Q_BASE      = 11'h048,
  parameter logic [10:0] NBR_BASE    = 11'h148,
  parameter int          NUM_ACTIONS = 32,
  parameter int          ALPHA_SHIFT = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] MY_CLUSTER_ID,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic        busy,
  output logic        accepted,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_RD_CLU, S_RD_VAL, S_RD_ACT,
    S_CHECK, S_RD_Q, S_WR_Q, S_WR_NBR, S_DONE
  } state_t;

  localparam logic [15:0] NUM_ACT = 16'(NUM_ACTIONS);

  // Moves old toward rew by 2^-ALPHA_SHIFT of the gap; the 17-bit gap keeps it exact.
  function automatic logic [15:0] q_update(input logic signed [15:0] old,
                                           input logic signed [15:0] rew);
    logic signed [16:0] diff;
    logic signed [16:0] delta;
    logic signed [16:0] sum;
    diff  = $signed({rew[15], rew}) - $signed({old[15], old});
    delta = diff >>> ALPHA_SHIFT;
    sum   = $signed({old[15], old}) + delta;
    return sum[15:0];
  endfunction

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d, clu_q, clu_d, rew_q, rew_d, act_q, act_d;
  logic        ok_q, ok_d;
  logic [10:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        wr_q, wr_d, busy_q, busy_d, acc_q, acc_d, done_q, done_d;
  logic        start_ok, chk_ok;
  logic [10:0] act_off;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign chk_ok   = (clu_q == MY_CLUSTER_ID) && (data_in < NUM_ACT);
  // In CHECK the action is still on data_in; it only lands in act_q on the way out.
  assign act_off  = (state_q == S_CHECK) ? {data_in[9:0], 1'b0} : {act_q[9:0], 1'b0};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      clu_q   <= '0;
      rew_q   <= '0;
      act_q   <= '0;
      ok_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      clu_q   <= clu_d;
      rew_q   <= rew_d;
      act_q   <= act_d;
      ok_q    <= ok_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    clu_d   = clu_q;
    rew_d   = rew_q;
    act_d   = act_q;
    ok_d    = ok_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) begin
        state_d = S_RD_SRC;
        ok_d    = 1'b0;
      end
      S_RD_SRC: state_d = S_RD_CLU;
      S_RD_CLU: begin state_d = S_RD_VAL; src_d = data_in; end
      S_RD_VAL: begin state_d = S_RD_ACT; clu_d = data_in; end
      S_RD_ACT: begin state_d = S_CHECK;  rew_d = data_in; end
      S_CHECK: begin
        act_d   = data_in;
        ok_d    = chk_ok;
        state_d = chk_ok ? S_RD_Q : S_DONE;
      end
      S_RD_Q:   state_d = S_WR_Q;
      S_WR_Q:   state_d = S_WR_NBR;
      S_WR_NBR: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = '0;
    dout_d = '0;
    wr_d   = 1'b0;
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    done_d = (state_d == S_DONE);
    acc_d  = (state_d == S_DONE) && ok_d;
    case (state_d)
      S_RD_SRC: addr_d = RX_BASE;
      S_RD_CLU: addr_d = RX_BASE + 11'd2;
      S_RD_VAL: addr_d = RX_BASE + 11'd4;
      S_RD_ACT: addr_d = RX_BASE + 11'd6;
      S_RD_Q:   addr_d = Q_BASE + act_off;
      S_WR_Q: begin
        addr_d = Q_BASE + act_off;
        wr_d   = 1'b1;
      end
      S_WR_NBR: begin
        addr_d = NBR_BASE + act_off;
        dout_d = src_q;
        wr_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign address  = addr_q;
  assign wr_en    = wr_q;
  assign busy     = busy_q;
  assign accepted = acc_q;
  assign done     = done_q;
  // The old Q value only arrives during WR_Q, so the update is formed combinationally there.
  assign data_out = (state_q == S_WR_Q) ? q_update($signed(data_in), $signed(rew_q)) : dout_q;

endmodule
